// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the CPU datapath.
//   Multiply: shift-add, LSB-first, WIDTH iterations, 2*WIDTH-bit product.
//   Divide:   restoring, MSB-first, WIDTH iterations; quotient truncates
//             toward zero, remainder takes the dividend's sign.
//   Optional feature macro: MD_UNSIGNED_EN. When defined, sgn selects
//   signed/unsigned per operation; otherwise every operation is signed.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op, sgn    request (IDLE only), 0=mul/1=div, 1=signed
//   a, b              multiplicand/dividend, multiplier/divisor
//   busy              high while not IDLE
//   done              one-cycle pulse; hi/lo/div_zero valid from this cycle
//   hi, lo            product upper/lower half, or remainder/quotient
//   div_zero          divide issued with b == 0; held until next start
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    state_t r_state, w_state_nxt;

    logic               r_op, r_neg_q, r_neg_r, r_done, r_div_zero;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;

    logic               w_signed, w_neg_a, w_neg_b, w_bzero, w_accept, w_fix;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rmd;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH+1:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MD_UNSIGNED_EN
    assign w_signed = sgn;
`else
    logic w_unused_sgn;
    assign w_unused_sgn = sgn;
    assign w_signed     = 1'b1;
`endif

    assign w_neg_a = w_signed & a[WIDTH-1];
    assign w_neg_b = w_signed & b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -a : a;
    assign w_mag_b = w_neg_b ? -b : b;
    assign w_bzero = (b == '0);

    // Multiply: r_acc = {partial sum, remaining multiplier bits}; r_opnd = |a|.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    // Divide: r_acc[WIDTH-1:0] shifts dividend bits out and quotient bits in;
    // r_opnd = |b|. Top bit of the trial difference is the borrow.
    assign w_trial = {r_rem, r_acc[WIDTH-1]} - {2'b00, r_opnd};

    assign w_prod  = r_neg_q ? -r_acc : r_acc;
    assign w_quo   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd   = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (op && w_bzero) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_op       <= op;
                r_neg_q    <= w_neg_a ^ w_neg_b;
                r_neg_r    <= w_neg_a;
                r_cnt      <= '0;
                r_div_zero <= op & w_bzero;
                r_opnd     <= op ? w_mag_b : w_mag_a;
                r_acc      <= {{WIDTH{1'b0}}, (op ? w_mag_a : w_mag_b)};
                r_rem      <= '0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_op) begin
                    r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_trial[WIDTH+1]};
                    r_rem <= w_trial[WIDTH+1] ? {r_rem[WIDTH-1:0], r_acc[WIDTH-1]}
                                              : w_trial[WIDTH:0];
                end else begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                end
            end
            // A divide-by-zero passes through FIX without touching hi/lo.
            if (w_fix && !r_div_zero) begin
                r_hi <= r_op ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_op ? w_quo : w_prod[WIDTH-1:0];
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;
endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: WIDTH=32 and WIDTH=8 instances, directed scenarios
// plus randomized operations against an arithmetic reference model.
module tb_md_unit;
`ifdef MD_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_start, s_op, s_sgn, s_busy, s_done, s_dz;
    logic [31:0] s_a, s_b, s_hi, s_lo;
    logic t_start, t_op, t_sgn, t_busy, t_done, t_dz;
    logic [7:0] t_a, t_b, t_hi, t_lo;
    int errors = 0;
    int checks = 0;

    md_unit #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .sgn(s_sgn),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done),
        .hi(s_hi), .lo(s_lo), .div_zero(s_dz)
    );
    md_unit #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst(rst), .start(t_start), .op(t_op), .sgn(t_sgn),
        .a(t_a), .b(t_b), .busy(t_busy), .done(t_done),
        .hi(t_hi), .lo(t_lo), .div_zero(t_dz)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic void model(input int w, input bit op, sg, input logic [63:0] a, b,
                                  inout logic [63:0] hi, lo, output bit dz);
        logic [63:0] mask;
        longint sa, sb, p, q, r;
        bit eff;
        eff  = UNS_EN ? sg : 1'b1;
        mask = (64'd1 << w) - 64'd1;
        sa   = longint'(a & mask);
        sb   = longint'(b & mask);
        if (eff) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        dz = 1'b0;
        if (!op) begin
            p  = sa * sb;
            lo = 64'(p) & mask;
            hi = (64'(p) >> w) & mask;
        end else if (sb == 0) begin
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = 64'(q) & mask;
            hi = 64'(r) & mask;
        end
    endfunction

    task automatic drive(input int w, input bit st, op, sg, input logic [63:0] a, b);
        if (w == 32) begin
            s_start = st; s_op = op; s_sgn = sg; s_a = a[31:0]; s_b = b[31:0];
        end else begin
            t_start = st; t_op = op; t_sgn = sg; t_a = a[7:0]; t_b = b[7:0];
        end
    endtask

    task automatic peek(input int w, output bit dn, bs, dz, output logic [63:0] h, l);
        if (w == 32) begin
            dn = s_done; bs = s_busy; dz = s_dz; h = {32'd0, s_hi}; l = {32'd0, s_lo};
        end else begin
            dn = t_done; bs = t_busy; dz = t_dz; h = {56'd0, t_hi}; l = {56'd0, t_lo};
        end
    endtask

    // Issue one operation and wait (bounded) for done. lat = edges from the
    // accepting edge to the edge that raised done, -1 on timeout.
    // pulse_at > 0 re-asserts start with different operands at that cycle.
    task automatic run(input int w, input bit op, sg, input logic [63:0] a, b, input int pulse_at,
                       output logic [63:0] h, l, output bit dz, output int lat,
                       output bit bs0, output bit bsd);
        bit dn, bs;
        drive(w, 1'b1, op, sg, a, b);
        @(posedge clk); #1;
        peek(w, dn, bs0, dz, h, l);
        lat = -1;
        bsd = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (n == pulse_at) drive(w, 1'b1, ~op, ~sg, ~a, ~b);
            else               drive(w, 1'b0, op, sg, a, b);
            @(posedge clk); #1;
            peek(w, dn, bs, dz, h, l);
            if (dn) begin
                lat = n;
                bsd = bs;
                break;
            end
        end
        drive(w, 1'b0, op, sg, a, b);
    endtask

    task automatic test_reset;
        bit dn, bs, dz;
        logic [63:0] h, l;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 8; w <= 32; w += 24) begin
            peek(w, dn, bs, dz, h, l);
            checks++; if (bs !== 1'b0) begin errors++; $display("FAIL reset_busy w%0d: got %b want 0", w, bs); end
            checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_done w%0d: got %b want 0", w, dn); end
            checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz w%0d: got %b want 0", w, dz); end
            checks++; if (h !== 64'd0) begin errors++; $display("FAIL reset_hi w%0d: got %h want 0", w, h); end
            checks++; if (l !== 64'd0) begin errors++; $display("FAIL reset_lo w%0d: got %h want 0", w, l); end
        end
        rst = 1'b0;
    endtask

    task automatic test_mult;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(32, 1'b0, 1'b1, 64'hFFFFFFFD, 64'd7, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (h !== 64'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want FFFFFFFF", h); end
        checks++; if (l !== 64'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want FFFFFFEB", l); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (bs0 !== 1'b1) begin errors++; $display("FAIL mult_busy_start: got %b want 1", bs0); end
        checks++; if (bsd !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", bsd); end
        @(posedge clk); #1;
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", s_done); end
    endtask

    task automatic test_div_signed;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(32, 1'b1, 1'b1, 64'd7, 64'hFFFFFFFE, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (l !== 64'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2_q: got %h want FFFFFFFD", l); end
        checks++; if (h !== 64'h00000001) begin errors++; $display("FAIL div_7_m2_r: got %h want 00000001", h); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
        run(32, 1'b1, 1'b1, 64'hFFFFFFF9, 64'd2, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (l !== 64'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2_q: got %h want FFFFFFFD", l); end
        checks++; if (h !== 64'hFFFFFFFF) begin errors++; $display("FAIL div_m7_2_r: got %h want FFFFFFFF", h); end
    endtask

    task automatic test_div_zero;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(32, 1'b1, 1'b1, 64'd95, 64'd10, 0, h, l, dz, lat, bs0, bsd);
        checks++; if ({h, l} !== {64'd5, 64'd9}) begin errors++; $display("FAIL div_95_10: got %h/%h want 5/9", h, l); end
        run(32, 1'b1, 1'b1, 64'd123, 64'd0, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dz); end
        checks++; if (h !== 64'd5) begin errors++; $display("FAIL dz_hi_hold: got %h want 5", h); end
        checks++; if (l !== 64'd9) begin errors++; $display("FAIL dz_lo_hold: got %h want 9", l); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        @(posedge clk); #1;
        checks++; if (s_dz !== 1'b1) begin errors++; $display("FAIL dz_held: got %b want 1", s_dz); end
        run(32, 1'b0, 1'b1, 64'd2, 64'd3, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_cleared: got %b want 0", dz); end
        checks++; if (l !== 64'd6) begin errors++; $display("FAIL mult_after_dz: got %h want 6", l); end
    endtask

    task automatic test_min_div_busy_start;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(32, 1'b1, 1'b1, 64'h80000000, 64'hFFFFFFFF, 5, h, l, dz, lat, bs0, bsd);
        checks++; if (l !== 64'h80000000) begin errors++; $display("FAIL min_div_q: got %h want 80000000", l); end
        checks++; if (h !== 64'd0) begin errors++; $display("FAIL min_div_r: got %h want 0", h); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL min_div_dz: got %b want 0", dz); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(32, 1'b0, 1'b1, 64'd3, 64'd4, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (l !== 64'd12) begin errors++; $display("FAIL b2b_first: got %h want c", l); end
        // still in the done cycle: next start is accepted on the following edge
        run(32, 1'b1, 1'b1, 64'd100, 64'd7, 0, h, l, dz, lat, bs0, bsd);
        checks++; if ({h, l} !== {64'd2, 64'd14}) begin errors++; $display("FAIL b2b_second: got %h/%h want 2/e", h, l); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    endtask

    task automatic test_abort;
        logic [63:0] h, l;
        bit dz, bs0, bsd, saw;
        int lat;
        drive(32, 1'b1, 1'b0, 1'b1, 64'h12345678, 64'h9ABCDEF0);
        @(posedge clk); #1;
        drive(32, 1'b0, 1'b0, 1'b1, 64'h12345678, 64'h9ABCDEF0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", s_busy); end
        checks++; if ({s_hi, s_lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h/%h want 0/0", s_hi, s_lo); end
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (s_done) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", saw); end
        run(32, 1'b0, 1'b1, 64'd6, 64'd7, 0, h, l, dz, lat, bs0, bsd);
        checks++; if ({h, l} !== {64'd0, 64'h2A}) begin errors++; $display("FAIL abort_then_mult: got %h/%h want 0/2a", h, l); end
    endtask

    task automatic test_rst_start;
        bit saw;
        drive(32, 1'b1, 1'b0, 1'b1, 64'd5, 64'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32, 1'b0, 1'b0, 1'b1, 64'd5, 64'd5);
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy: got %b want 0", s_busy); end
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (s_done) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_start_no_done: got %b want 0", saw); end
    endtask

    task automatic test_unsigned;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        logic [63:0] eh;
        eh = UNS_EN ? 64'h00000001 : 64'hFFFFFFFF;
        run(32, 1'b0, 1'b0, 64'hFFFFFFFF, 64'd2, 0, h, l, dz, lat, bs0, bsd);
        checks++; if (h !== eh) begin errors++; $display("FAIL sgn0_mult_hi: got %h want %h", h, eh); end
        checks++; if (l !== 64'hFFFFFFFE) begin errors++; $display("FAIL sgn0_mult_lo: got %h want FFFFFFFE", l); end
    endtask

    task automatic test_w8;
        logic [63:0] h, l;
        bit dz, bs0, bsd;
        int lat;
        run(8, 1'b0, 1'b1, 64'h80, 64'h80, 0, h, l, dz, lat, bs0, bsd);
        checks++; if ({h, l} !== {64'h40, 64'h00}) begin errors++; $display("FAIL w8_mult: got %h/%h want 40/00", h, l); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL w8_latency: got %0d want 9", lat); end
        run(8, 1'b1, 1'b1, 64'h80, 64'hFF, 0, h, l, dz, lat, bs0, bsd);
        checks++; if ({h, l} !== {64'h00, 64'h80}) begin errors++; $display("FAIL w8_min_div: got %h/%h want 00/80", h, l); end
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom % 8)
            0:       return 64'd0;
            1:       return 64'd1 << (w - 1);
            2:       return mask;
            3:       return 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic test_random;
        logic [63:0] h, l, a, b, mh, ml;
        bit dz, bs0, bsd, mdz, op, sg;
        int lat, elat;
        for (int w = 8; w <= 32; w += 24) begin
            mh = '0;
            ml = '0;
            for (int i = 0; i < 30; i++) begin
                op = 1'($urandom % 2);
                sg = 1'($urandom % 2);
                a  = pick(w);
                b  = pick(w);
                if (i == 0 && b == 64'd0) b = 64'd3;
                model(w, op, sg, a, b, mh, ml, mdz);
                elat = mdz ? 1 : w + 1;
                run(w, op, sg, a, b, 0, h, l, dz, lat, bs0, bsd);
                checks++; if ({h, l} !== {mh, ml}) begin errors++; $display("FAIL rand w%0d op%0d sg%0d a=%h b=%h: got %h/%h want %h/%h", w, op, sg, a, b, h, l, mh, ml); end
                checks++; if (dz !== mdz) begin errors++; $display("FAIL rand_dz w%0d a=%h b=%h: got %b want %b", w, a, b, dz, mdz); end
                checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency w%0d: got %0d want %0d", w, lat, elat); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        drive(32, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        test_reset;
        test_mult;
        test_div_signed;
        test_div_zero;
        test_min_div_busy_start;
        test_back_to_back;
        test_abort;
        test_rst_start;
        test_unsigned;
        test_w8;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
